// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: per-latch enable/flush and PC enable from cache hits,
// load-use hazards, taken redirects and halt, with a data-memory wait FSM and stall counter.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ihit_i,
  input  logic             dhit_i,
  input  logic             mem_dreq_i,
  input  logic             mem_br_taken_i,
  input  logic             mem_jump_i,
  input  logic             mem_halt_i,
  input  logic             ex_dren_i,
  input  logic [REG_W-1:0] ex_wsel_i,
  input  logic [REG_W-1:0] de_rs_i,
  input  logic [REG_W-1:0] de_rt_i,
  input  logic             de_uses_rt_i,
  output logic             pc_en_o,
  output logic             fl_en_o,
  output logic             fl_flush_o,
  output logic             dl_en_o,
  output logic             dl_flush_o,
  output logic             el_en_o,
  output logic             el_flush_o,
  output logic             ml_en_o,
  output logic             ml_flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_e;

  // Latch index: 0 fetch, 1 decode, 2 execute, 3 memory.
  localparam int NLAT = 4;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             load_use;
  logic             redirect;
  logic             run_pc_en;
  logic [NLAT-1:0]  run_en;
  logic [NLAT-1:0]  run_flush;
  logic             pc_en;
  logic [NLAT-1:0]  lat_en;
  logic [NLAT-1:0]  lat_flush;
  logic             stall_inc;

  // A load writing $0 never produces a value the decode stage could be waiting on.
  assign load_use = ex_dren_i && (ex_wsel_i != '0) &&
                    ((ex_wsel_i == de_rs_i) || (de_uses_rt_i && (ex_wsel_i == de_rt_i)));
  assign redirect = mem_br_taken_i || mem_jump_i;

  // Redirect, load-use, ifetch miss and normal advance; shared by RUN and the DWAIT exit cycle.
  always_comb begin
    run_pc_en = 1'b0;
    run_en    = '0;
    run_flush = '0;
    if (redirect) begin
      run_pc_en = 1'b1;
      run_flush = 4'b0111;
      run_en    = 4'b1000;
    end else if (load_use) begin
      run_flush = 4'b0010;
      run_en    = 4'b1100;
    end else if (!ihit_i) begin
      run_flush = 4'b0001;
      run_en    = 4'b1110;
    end else begin
      run_pc_en = 1'b1;
      run_en    = 4'b1111;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_en     = 1'b0;
    lat_en    = '0;
    lat_flush = '0;
    case (state_q)
      RUN: begin
        if (mem_halt_i) begin
          state_d = HALT;
        end else if (redirect) begin
          pc_en     = run_pc_en;
          lat_en    = run_en;
          lat_flush = run_flush;
        end else if (mem_dreq_i && !dhit_i) begin
          state_d = DWAIT;
        end else begin
          pc_en     = run_pc_en;
          lat_en    = run_en;
          lat_flush = run_flush;
        end
      end
      DWAIT: begin
        if (dhit_i) begin
          state_d   = RUN;
          pc_en     = run_pc_en;
          lat_en    = run_en;
          lat_flush = run_flush;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign stall_inc = !pc_en && (state_q != HALT) && !mem_halt_i;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset forces every control low even though the state already reads RUN.
  logic [NLAT-1:0] en_out;
  logic [NLAT-1:0] flush_out;

  generate
    for (genvar gi = 0; gi < NLAT; gi++) begin : g_lat
      assign en_out[gi]    = lat_en[gi] && !rst_i;
      assign flush_out[gi] = lat_flush[gi] && !rst_i;
    end
  endgenerate

  assign pc_en_o     = pc_en && !rst_i;
  assign fl_en_o     = en_out[0];
  assign fl_flush_o  = flush_out[0];
  assign dl_en_o     = en_out[1];
  assign dl_flush_o  = flush_out[1];
  assign el_en_o     = en_out[2];
  assign el_flush_o  = flush_out[2];
  assign ml_en_o     = en_out[3];
  assign ml_flush_o  = flush_out[3];
  assign halted_o    = (state_q == HALT);
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: rule table in RUN plus reset, dcache wait,
// redirect, halt and counter saturation sequences.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ihit = 1'b0, dhit = 1'b0, dreq = 1'b0, br = 1'b0, jmp = 1'b0, mhalt = 1'b0;
  logic       dren = 1'b0, uses_rt = 1'b0;
  logic [4:0] wsel = '0, rs = '0, rt = '0;

  logic        pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush, halted;
  logic [31:0] stall_cnt;

  logic       rst2 = 1'b0;
  logic       ihit2 = 1'b0;
  logic       zero1 = 1'b0;
  logic [4:0] zero5 = '0;
  logic       s_pc, s_fe, s_ff, s_de, s_df, s_ee, s_ef, s_me, s_mf, s_halt;
  logic [3:0] s_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .ihit_i(ihit), .dhit_i(dhit), .mem_dreq_i(dreq),
    .mem_br_taken_i(br), .mem_jump_i(jmp), .mem_halt_i(mhalt), .ex_dren_i(dren),
    .ex_wsel_i(wsel), .de_rs_i(rs), .de_rt_i(rt), .de_uses_rt_i(uses_rt),
    .pc_en_o(pc_en), .fl_en_o(fl_en), .fl_flush_o(fl_flush), .dl_en_o(dl_en),
    .dl_flush_o(dl_flush), .el_en_o(el_en), .el_flush_o(el_flush), .ml_en_o(ml_en),
    .ml_flush_o(ml_flush), .halted_o(halted), .stall_cnt_o(stall_cnt)
  );

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst2), .ihit_i(ihit2), .dhit_i(zero1), .mem_dreq_i(zero1),
    .mem_br_taken_i(zero1), .mem_jump_i(zero1), .mem_halt_i(zero1), .ex_dren_i(zero1),
    .ex_wsel_i(zero5), .de_rs_i(zero5), .de_rt_i(zero5), .de_uses_rt_i(zero1),
    .pc_en_o(s_pc), .fl_en_o(s_fe), .fl_flush_o(s_ff), .dl_en_o(s_de),
    .dl_flush_o(s_df), .el_en_o(s_ee), .el_flush_o(s_ef), .ml_en_o(s_me),
    .ml_flush_o(s_mf), .halted_o(s_halt), .stall_cnt_o(s_cnt)
  );

  // {pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush}
  logic [8:0] obs;
  assign obs = {pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush};

  localparam logic [8:0] O_NORM = 9'b1_10_10_10_10;
  localparam logic [8:0] O_LU   = 9'b0_00_01_10_10;
  localparam logic [8:0] O_IB   = 9'b0_01_10_10_10;
  localparam logic [8:0] O_RD   = 9'b1_01_01_01_10;
  localparam logic [8:0] O_ZERO = 9'b0_00_00_00_00;

  typedef struct {
    string      name;
    logic       ihit, dhit, dreq, br, jmp, dren, uses_rt;
    logic [4:0] wsel, rs, rt;
    logic [8:0] exp;
    int         inc;
  } vec_t;

  vec_t vecs[12];
  int   checks = 0;
  int   passes = 0;
  int   exp_cnt = 0;

  function automatic vec_t mk(string n, logic ih, logic dh, logic dq, logic b, logic j,
                              logic dr, logic [4:0] ws, logic [4:0] s, logic [4:0] t,
                              logic ur, logic [8:0] e, int inc);
    vec_t v;
    v.name = n; v.ihit = ih; v.dhit = dh; v.dreq = dq; v.br = b; v.jmp = j;
    v.dren = dr; v.wsel = ws; v.rs = s; v.rt = t; v.uses_rt = ur; v.exp = e; v.inc = inc;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; dreq = 1'b0; br = 1'b0; jmp = 1'b0; mhalt = 1'b0;
    dren = 1'b0; uses_rt = 1'b0; wsel = '0; rs = '0; rt = '0;
  endtask

  initial begin
    vecs[0]  = mk("normal",          1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_NORM, 0);
    vecs[1]  = mk("lu_rs",           1, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd1, 0, O_LU,   1);
    vecs[2]  = mk("lu_r0_ignored",   1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, O_NORM, 0);
    vecs[3]  = mk("lu_rt",           1, 0, 0, 0, 0, 1, 5'd9, 5'd3, 5'd9, 1, O_LU,   1);
    vecs[4]  = mk("rt_not_used",     1, 0, 0, 0, 0, 1, 5'd9, 5'd3, 5'd9, 0, O_NORM, 0);
    vecs[5]  = mk("no_load",         1, 0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd8, 1, O_NORM, 0);
    vecs[6]  = mk("imiss",           0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_IB,   1);
    vecs[7]  = mk("lu_over_imiss",   0, 0, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0, O_LU,   1);
    vecs[8]  = mk("branch_imiss",    0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_RD,   0);
    vecs[9]  = mk("jump_over_lu",    1, 0, 0, 0, 1, 1, 5'd7, 5'd7, 5'd0, 0, O_RD,   0);
    vecs[10] = mk("dreq_hit",        1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_NORM, 0);
    vecs[11] = mk("dreq_hit_lu",     1, 1, 1, 0, 0, 1, 5'd2, 5'd5, 5'd2, 1, O_LU,   1);

    // Reset with ihit held high
    idle_inputs();
    #1 rst = 1'b1; rst2 = 1'b1;
    #1;
    check("rst_outs", {23'd0, obs}, {23'd0, O_ZERO});
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_cnt", stall_cnt, 32'd0);
    tick();
    check("rst_outs_clk", {23'd0, obs}, {23'd0, O_ZERO});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_outs", {23'd0, obs}, {23'd0, O_NORM});
    exp_cnt = 0;
    @(posedge clk);
    #1;

    // Rule table in RUN
    for (int i = 0; i < 12; i++) begin
      ihit = vecs[i].ihit; dhit = vecs[i].dhit; dreq = vecs[i].dreq; br = vecs[i].br;
      jmp = vecs[i].jmp; dren = vecs[i].dren; wsel = vecs[i].wsel; rs = vecs[i].rs;
      rt = vecs[i].rt; uses_rt = vecs[i].uses_rt; mhalt = 1'b0;
      #1;
      check({vecs[i].name, "_outs"}, {23'd0, obs}, {23'd0, vecs[i].exp});
      tick();
      exp_cnt += vecs[i].inc;
      check({vecs[i].name, "_cnt"}, stall_cnt, exp_cnt);
      $display("vec %0d %s: outs=%b cnt=%0d", i, vecs[i].name, obs, stall_cnt);
    end

    // Branch with imiss, then normal on the following cycle
    idle_inputs();
    ihit = 1'b0; br = 1'b1;
    #1 check("br_outs", {23'd0, obs}, {23'd0, O_RD});
    tick();
    idle_inputs();
    #1 check("br_next_outs", {23'd0, obs}, {23'd0, O_NORM});
    tick();
    check("br_cnt", stall_cnt, exp_cnt);

    // Dcache miss: three stalled cycles then the hit cycle advances
    idle_inputs();
    dreq = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check("dwait_outs", {23'd0, obs}, {23'd0, O_ZERO});
      tick();
      exp_cnt++;
      check("dwait_cnt", stall_cnt, exp_cnt);
      $display("dwait cycle %0d: outs=%b cnt=%0d", c, obs, stall_cnt);
    end
    dhit = 1'b1;
    #1 check("dhit_outs", {23'd0, obs}, {23'd0, O_NORM});
    tick();
    check("dhit_cnt", stall_cnt, exp_cnt);
    idle_inputs();
    #1 check("after_dwait_outs", {23'd0, obs}, {23'd0, O_NORM});
    tick();

    // Reset arriving mid-DWAIT leaves nothing pending
    idle_inputs();
    dreq = 1'b1;
    tick();
    dreq = 1'b0;
    #1 check("dwait_held", {23'd0, obs}, {23'd0, O_ZERO});
    #1 rst = 1'b1;
    #1 check("mid_rst_outs", {23'd0, obs}, {23'd0, O_ZERO});
    #1 rst = 1'b0;
    #1 check("mid_rst_run", {23'd0, obs}, {23'd0, O_NORM});
    exp_cnt = 0;
    check("mid_rst_cnt", stall_cnt, exp_cnt);
    @(posedge clk);
    #1;

    // Halt beats a same-cycle taken branch and is sticky
    idle_inputs();
    dren = 1'b1; wsel = 5'd3; rs = 5'd3;
    #1 check("pre_halt_lu", {23'd0, obs}, {23'd0, O_LU});
    tick();
    exp_cnt++;
    idle_inputs();
    mhalt = 1'b1; br = 1'b1;
    #1 check("halt_outs", {23'd0, obs}, {23'd0, O_ZERO});
    tick();
    check("halt_cnt", stall_cnt, exp_cnt);
    idle_inputs();
    ihit = 1'b0; br = 1'b1; dreq = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("halted", {31'd0, halted}, 32'd1);
      check("halted_outs", {23'd0, obs}, {23'd0, O_ZERO});
      tick();
      check("halted_cnt", stall_cnt, exp_cnt);
      $display("halt cycle %0d: halted=%0d outs=%b cnt=%0d", c, halted, obs, stall_cnt);
    end
    idle_inputs();
    #1 rst = 1'b1;
    #1;
    check("halt_rst_halted", {31'd0, halted}, 32'd0);
    check("halt_rst_cnt", stall_cnt, 32'd0);
    #1 rst = 1'b0;
    #1 check("halt_rst_run", {23'd0, obs}, {23'd0, O_NORM});

    // Saturating counter on the 4-bit instance
    @(negedge clk);
    ihit2 = 1'b0;
    rst2 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 14) check("sat_cnt_14", {28'd0, s_cnt}, 32'd14);
    end
    check("sat_cnt_final", {28'd0, s_cnt}, 32'd15);
    check("sat_pc_en", {31'd0, s_pc}, 32'd0);
    $display("saturation: cnt=%0d", s_cnt);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
